fetch_ctrl: RTL

Instruction-fetch sequencer for the IF stage. It owns the fetch PC and issues one request at a time to the I-cache. It pushes returned instruction pairs (address, data, TLB flags) into the 16-entry instruction FIFO through that FIFO's dual write ports. It throttles on FIFO `full` and handles redirects: it resets the FIFO and discards any in-flight response that belongs to the old path.

---
 rtl/fetch_ctrl_if.sv | 46 ++++
 rtl/fetch_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/fetch_ctrl_if.sv
// I-cache request/response and FIFO dual-write bundle for the fetch sequencer.
interface fetch_ctrl_if;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_addr_ok;
    logic        icache_data_ok;
    logic [31:0] icache_rdata1;
    logic [31:0] icache_rdata2;
    logic        icache_valid2;
    logic        icache_refill;
    logic        icache_invalid;
    logic        write_en1;
    logic        write_en2;
    logic [31:0] write_address1;
    logic [31:0] write_address2;
    logic [31:0] write_data1;
    logic [31:0] write_data2;
    logic        write_tlb_refill1;
    logic        write_tlb_refill2;
    logic        write_tlb_invalid1;
    logic        write_tlb_invalid2;

    modport master (
        output icache_req, icache_addr,
        input  icache_addr_ok, icache_data_ok,
        input  icache_rdata1, icache_rdata2,
        input  icache_valid2, icache_refill, icache_invalid,
        output write_en1, write_en2,
        output write_address1, write_address2,
        output write_data1, write_data2,
        output write_tlb_refill1, write_tlb_refill2,
        output write_tlb_invalid1, write_tlb_invalid2
    );

    modport slave (
        input  icache_req, icache_addr,
        output icache_addr_ok, icache_data_ok,
        output icache_rdata1, icache_rdata2,
        output icache_valid2, icache_refill, icache_invalid,
        input  write_en1, write_en2,
        input  write_address1, write_address2,
        input  write_data1, write_data2,
        input  write_tlb_refill1, write_tlb_refill2,
        input  write_tlb_invalid1, write_tlb_invalid2
    );
endinterface

// File: rtl/fetch_ctrl.sv
// IF-stage fetch sequencer: one outstanding I-cache request, pair writes
// into the instruction FIFO, redirect with stale-response discard.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC0_0000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         redirect,
    input  logic [31:0]  redirect_pc,
    input  logic         fifo_full,
    output logic         fifo_rst,
    fetch_ctrl_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT
    } state_t;

    state_t      r_state;
    logic [31:0] r_pc;
    logic [31:0] r_addr;
    logic        r_req;
    logic        r_discard;

    logic        w_accept;
    logic        w_en2;
    logic [31:0] w_pc4;
    logic [31:0] w_next_pc;

    assign w_accept  = (r_state == S_WAIT) && bus.icache_data_ok
                     && !r_discard && !redirect;
    assign w_en2     = w_accept && bus.icache_valid2 && !r_pc[2];
    assign w_pc4     = r_pc + 32'd4;
    assign w_next_pc = r_pc + (w_en2 ? 32'd8 : 32'd4);

    assign fifo_rst               = redirect;
    assign bus.icache_req         = r_req;
    assign bus.icache_addr        = r_addr;
    assign bus.write_en1          = w_accept;
    assign bus.write_en2          = w_en2;
    assign bus.write_address1     = r_pc;
    assign bus.write_address2     = w_pc4;
    assign bus.write_data1        = bus.icache_rdata1;
    assign bus.write_data2        = bus.icache_rdata2;
    assign bus.write_tlb_refill1  = bus.icache_refill;
    assign bus.write_tlb_refill2  = bus.icache_refill;
    assign bus.write_tlb_invalid1 = bus.icache_invalid;
    assign bus.write_tlb_invalid2 = bus.icache_invalid;

    // r_addr holds the issued address so a redirect in REQ cannot move it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_addr    <= RESET_PC;
            r_req     <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            if (redirect) begin
                r_pc <= redirect_pc;
            end
            unique case (r_state)
                S_IDLE: begin
                    if (!redirect && !fifo_full) begin
                        r_state <= S_REQ;
                        r_req   <= 1'b1;
                        r_addr  <= r_pc;
                    end
                end
                S_REQ: begin
                    if (redirect) begin
                        r_discard <= 1'b1;
                    end
                    if (bus.icache_addr_ok) begin
                        r_state <= S_WAIT;
                        r_req   <= 1'b0;
                    end
                end
                S_WAIT: begin
                    if (bus.icache_data_ok) begin
                        r_state   <= S_IDLE;
                        r_discard <= 1'b0;
                        if (w_accept) begin
                            r_pc <= w_next_pc;
                        end
                    end else if (redirect) begin
                        r_discard <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_req   <= 1'b0;
                end
            endcase
        end
    end
endmodule
